// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch (I, read-only)
// and the memory stage (D, load/store), with D-side lane steering and alignment.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [31:0]       i_rdata_o,
    output logic              i_rvalid_o,
    output logic              i_busy_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_done_o,
    output logic              d_err_o,
    output logic              d_busy_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [3:0]        ram_be_o,
    input  logic              ram_ready_i,
    input  logic [31:0]       ram_rdata_i,
    input  logic              ram_rvalid_i
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   starve_q;
    logic               owner_d_q;
    logic [1:0]         shift_q;

    logic               d_req;
    logic               starve_hit;
    logic               grant_d;
    logic               grant_i;
    logic               d_misalign;
    logic [3:0]         d_be;
    logic [31:0]        d_wdata;
    logic               unused_bits;

    assign unused_bits = ^{d_funct3_i[2], i_addr_i[1:0]};

    assign d_req      = d_read_i | d_write_i;
    assign starve_hit = i_req_i && (starve_q == CNT_W'(STARVE_LIMIT));
    assign grant_d    = d_req && !starve_hit;
    assign grant_i    = i_req_i && !grant_d;

    assign d_busy_o = d_req & ~d_done_o;
    assign i_busy_o = i_req_i & ~i_rvalid_o;

    // Store lane steering and alignment check; reads always enable all lanes
    always_comb begin
        d_be       = 4'b1111;
        d_wdata    = d_wdata_i;
        d_misalign = 1'b0;
        case (d_funct3_i[1:0])
            2'b00: begin
                d_be    = 4'b0001 << d_addr_i[1:0];
                d_wdata = {4{d_wdata_i[7:0]}};
            end
            2'b01: begin
                d_be       = 4'b0011 << {d_addr_i[1], 1'b0};
                d_wdata    = {2{d_wdata_i[15:0]}};
                d_misalign = d_addr_i[0];
            end
            2'b10:   d_misalign = (d_addr_i[1:0] != 2'b00);
            default: d_misalign = 1'b1;
        endcase
        if (!d_write_i) begin
            d_be = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            owner_d_q   <= 1'b0;
            shift_q     <= 2'b00;
            i_rdata_o   <= '0;
            i_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_done_o    <= 1'b0;
            d_err_o     <= 1'b0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_be_o    <= '0;
        end else begin
            i_rvalid_o <= 1'b0;
            d_done_o   <= 1'b0;
            d_err_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        // A misaligned access still counts against I's wait
                        if (!i_req_i) begin
                            starve_q <= '0;
                        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
                            starve_q <= starve_q + CNT_W'(1);
                        end
                        if (d_misalign) begin
                            d_done_o  <= 1'b1;
                            d_err_o   <= 1'b1;
                            d_rdata_o <= '0;
                        end else begin
                            owner_d_q   <= 1'b1;
                            shift_q     <= d_addr_i[1:0];
                            ram_req_o   <= 1'b1;
                            ram_we_o    <= d_write_i;
                            ram_addr_o  <= {d_addr_i[ADDR_W-1:2], 2'b00};
                            ram_wdata_o <= d_write_i ? d_wdata : 32'h0;
                            ram_be_o    <= d_be;
                            state_q     <= REQ;
                        end
                    end else if (grant_i) begin
                        starve_q    <= '0;
                        owner_d_q   <= 1'b0;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= 1'b0;
                        ram_addr_o  <= {i_addr_i[ADDR_W-1:2], 2'b00};
                        ram_wdata_o <= '0;
                        ram_be_o    <= 4'b1111;
                        state_q     <= REQ;
                    end else begin
                        starve_q <= '0;
                    end
                end
                REQ: begin
                    if (ram_ready_i) begin
                        ram_req_o <= 1'b0;
                        if (ram_we_o) begin
                            d_done_o <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (ram_rvalid_i) begin
                        state_q <= IDLE;
                        if (owner_d_q) begin
                            d_done_o  <= 1'b1;
                            d_rdata_o <= ram_rdata_i >> {shift_q, 3'b000};
                        end else begin
                            i_rvalid_o <= 1'b1;
                            i_rdata_o  <= ram_rdata_i;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset abandon, store lanes, load alignment,
// misaligned errors, starvation ordering and RAM back-pressure.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_rvalid_o;
    logic        i_busy_o;
    logic        d_read_i;
    logic        d_write_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [2:0]  d_funct3_i;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        d_err_o;
    logic        d_busy_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic        ram_ready_i;
    logic [31:0] ram_rdata_i = '0;
    logic        ram_rvalid_i = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          rv_delay = 0;
    int          rv_cnt = 0;
    logic [31:0] rd_val = '0;
    logic        mon_en = 1'b0;
    logic        grants[$];
    logic [9:0]  exp_pat;
    logic        done5;

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
        .i_rvalid_o(i_rvalid_o), .i_busy_o(i_busy_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_funct3_i(d_funct3_i), .d_rdata_o(d_rdata_o),
        .d_done_o(d_done_o), .d_err_o(d_err_o), .d_busy_o(d_busy_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_ready_i(ram_ready_i),
        .ram_rdata_i(ram_rdata_i), .ram_rvalid_i(ram_rvalid_i)
    );

    always #5 clk = ~clk;

    // RAM responder: read data returns rv_delay cycles after the accept cycle's successor
    always @(posedge clk) begin
        ram_rvalid_i <= 1'b0;
        if (ram_req_o && ram_ready_i && !ram_we_o) begin
            if (rv_delay == 0) begin
                ram_rvalid_i <= 1'b1;
                ram_rdata_i  <= rd_val;
            end else begin
                rv_cnt <= rv_delay;
            end
        end else if (rv_cnt != 0) begin
            rv_cnt <= rv_cnt - 1;
            if (rv_cnt == 1) begin
                ram_rvalid_i <= 1'b1;
                ram_rdata_i  <= rd_val;
            end
        end
    end

    always @(posedge clk) begin
        if (mon_en && ram_req_o && ram_ready_i) grants.push_back(ram_we_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic d_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rd, input logic [31:0] exp);
        cyc();
        d_read_i = 1'b1; d_addr_i = a; d_funct3_i = f3; rd_val = rd; rv_delay = 0;
        cyc(); cyc(); cyc();
        check({tag, "_done"}, d_done_o, 1);
        check({tag, "_err"}, d_err_o, 0);
        check({tag, "_data"}, d_rdata_o, exp);
        d_read_i = 1'b0;
    endtask

    task automatic d_bad(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] f3);
        cyc();
        d_read_i = !wr; d_write_i = wr; d_addr_i = a; d_funct3_i = f3;
        mid();
        check({tag, "_busy"}, d_busy_o, 1);
        cyc();
        check({tag, "_done"}, d_done_o, 1);
        check({tag, "_err"}, d_err_o, 1);
        check({tag, "_data"}, d_rdata_o, 0);
        d_read_i = 1'b0; d_write_i = 1'b0;
        mid();
        check({tag, "_noreq"}, ram_req_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_req_i = 0; i_addr_i = 0; d_read_i = 0; d_write_i = 0;
        d_addr_i = 0; d_wdata_i = 0; d_funct3_i = 0; ram_ready_i = 1'b1;
        cyc(); cyc(); mid();
        check("rst_req", ram_req_o, 0);
        check("rst_done", d_done_o, 0);
        check("rst_ivalid", i_rvalid_o, 0);
        check("rst_be", ram_be_o, 0);

        // Plain fetch
        cyc();
        reset = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h80; rd_val = 32'hDEADBEEF; rv_delay = 0;
        cyc(); mid();
        check("if_addr", ram_addr_o, 32'h80);
        check("if_be", ram_be_o, 4'hF);
        cyc(); mid();
        check("if_busy", i_busy_o, 1);
        cyc();
        check("if_valid", i_rvalid_o, 1);
        check("if_data", i_rdata_o, 32'hDEADBEEF);
        check("if_busy_end", i_busy_o, 0);
        i_req_i = 1'b0;

        // Reset while in RESP: the late response must be dropped
        cyc();
        i_req_i = 1'b1; i_addr_i = 32'h44; rd_val = 32'hCAFEF00D; rv_delay = 2;
        cyc(); mid();
        check("t1_req", ram_req_o, 1);
        check("t1_addr", ram_addr_o, 32'h44);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; i_req_i = 1'b0;
        mid();
        check("t1_req0", ram_req_o, 0);
        check("t1_we0", ram_we_o, 0);
        check("t1_addr0", ram_addr_o, 0);
        check("t1_be0", ram_be_o, 0);
        check("t1_wdata0", ram_wdata_o, 0);
        check("t1_ivalid0", i_rvalid_o, 0);
        check("t1_idata0", i_rdata_o, 0);
        check("t1_ddata0", d_rdata_o, 0);
        check("t1_done0", d_done_o, 0);
        check("t1_err0", d_err_o, 0);
        cyc(); mid();
        check("t1_ivalid_a", i_rvalid_o, 0);
        cyc(); mid();
        check("t1_ivalid_b", i_rvalid_o, 0);
        check("t1_idata_b", i_rdata_o, 0);
        rv_delay = 0;

        // SB to 0x103
        cyc();
        d_write_i = 1'b1; d_addr_i = 32'h103; d_wdata_i = 32'hA5; d_funct3_i = 3'b000;
        mid();
        check("sb_busy_n", d_busy_o, 1);
        cyc(); mid();
        check("sb_req", ram_req_o, 1);
        check("sb_we", ram_we_o, 1);
        check("sb_addr", ram_addr_o, 32'h100);
        check("sb_be", ram_be_o, 4'b1000);
        check("sb_wdata", ram_wdata_o, 32'hA5A5A5A5);
        check("sb_done_early", d_done_o, 0);
        cyc();
        check("sb_done", d_done_o, 1);
        check("sb_err", d_err_o, 0);
        check("sb_busy_end", d_busy_o, 0);
        d_write_i = 1'b0;
        mid();
        check("sb_idle", ram_req_o, 0);

        // LH from 0x202
        cyc();
        d_read_i = 1'b1; d_addr_i = 32'h202; d_funct3_i = 3'b001; rd_val = 32'hBEEF1234;
        mid();
        check("lh_busy_n", d_busy_o, 1);
        cyc(); mid();
        check("lh_req", ram_req_o, 1);
        check("lh_we", ram_we_o, 0);
        check("lh_addr", ram_addr_o, 32'h200);
        check("lh_be", ram_be_o, 4'hF);
        check("lh_busy_n1", d_busy_o, 1);
        cyc(); mid();
        check("lh_busy_n2", d_busy_o, 1);
        check("lh_done_early", d_done_o, 0);
        cyc();
        check("lh_done", d_done_o, 1);
        check("lh_data", d_rdata_o, 32'h0000BEEF);
        check("lh_busy_n3", d_busy_o, 0);
        d_read_i = 1'b0;

        d_load("lb", 32'h203, 3'b000, 32'hBEEF1234, 32'h000000BE);
        d_load("lw", 32'h204, 3'b010, 32'h89ABCDEF, 32'h89ABCDEF);

        // Misaligned accesses
        d_bad("sw_misal", 1'b1, 32'h006, 3'b010);
        d_bad("lh_misal", 1'b0, 32'h201, 3'b001);
        d_bad("f3_11", 1'b0, 32'h000, 3'b011);

        // Starvation: D held, I held (address changes after each completion)
        cyc();
        grants.delete();
        mon_en = 1'b1;
        i_req_i = 1'b1; i_addr_i = 32'h100;
        d_write_i = 1'b1; d_addr_i = 32'h10; d_funct3_i = 3'b010; d_wdata_i = 32'h11223344;
        done5 = 1'b0;
        for (int c = 0; c < 200 && !done5; c++) begin
            cyc();
            if (i_rvalid_o) begin
                if (grants.size() >= 10) begin
                    i_req_i = 1'b0; d_write_i = 1'b0; done5 = 1'b1;
                end else begin
                    i_addr_i = i_addr_i + 32'd4;
                end
            end
        end
        mon_en = 1'b0;
        check("starve_timeout", done5, 1);
        check("starve_count", grants.size(), 10);
        exp_pat = 10'b1111011110;
        for (int k = 0; k < 10; k++) begin
            if (k < grants.size()) check($sformatf("grant%0d_we", k), grants[k], exp_pat[9-k]);
        end

        // Write under RAM back-pressure
        cyc(); cyc();
        ram_ready_i = 1'b0;
        d_write_i = 1'b1; d_addr_i = 32'h0A2; d_wdata_i = 32'h00001234; d_funct3_i = 3'b001;
        for (int k = 0; k < 5; k++) begin
            cyc(); mid();
            check($sformatf("bp%0d_req", k), ram_req_o, 1);
            check($sformatf("bp%0d_addr", k), ram_addr_o, 32'h0A0);
            check($sformatf("bp%0d_wdata", k), ram_wdata_o, 32'h12341234);
            check($sformatf("bp%0d_be", k), ram_be_o, 4'b1100);
            check($sformatf("bp%0d_busy", k), d_busy_o, 1);
        end
        cyc();
        ram_ready_i = 1'b1;
        mid();
        check("bp_busy_acc", d_busy_o, 1);
        cyc();
        check("bp_done", d_done_o, 1);
        check("bp_busy_end", d_busy_o, 0);
        d_write_i = 1'b0;
        mid();
        check("bp_idle", ram_req_o, 0);

        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
